// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: FSM states, response codes and the
// byte-address shift used to turn word addresses into AXI byte addresses.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    RADDR,
    RDATA
  } axil_state_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axil_resp_e;

  // log2 of the number of bytes per AXI data beat.
  function automatic int unsigned byte_shift(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axil_wr_channel_tracker.sv
// Tracks independent AW and W acceptance for one write; both_done_o fires in
// the cycle the later of the two handshakes completes.
module axil_wr_channel_tracker (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic aw_hs_i,
  input  logic w_hs_i,
  output logic both_done_o
);

  logic aw_done_q;
  logic w_done_q;

  // NOTE: reset is synchronous here, so it lives inside the clocked block
  // rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst || start_i || both_done_o) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (aw_hs_i) aw_done_q <= 1'b1;
      if (w_hs_i)  w_done_q  <= 1'b1;
    end
  end

  assign both_done_o = (aw_done_q | aw_hs_i) & (w_done_q | w_hs_i);

endmodule

// File: rtl/native_axil_master.sv
// Native single-word request port to AXI4-Lite initiator, one transaction
// outstanding, completion reported by a one-cycle NATIVE_READY pulse.
module native_axil_master
  import axil_pkg::*;
#(
  parameter int                          NATIVE_ADDR_WDITH = 4,
  parameter int                          NATIVE_DATA_WIDTH = 32,
  parameter int                          M_AXI_ADDR_WIDTH  = 32,
  parameter int                          M_AXI_DATA_WIDTH  = 32,
  parameter logic [M_AXI_ADDR_WIDTH-1:0] BASE_ADDR         = '0
) (
  input  logic                          M_AXI_aclk,
  input  logic                          M_AXI_areset,
  input  logic                          NATIVE_EN,
  input  logic                          NATIVE_WR,
  input  logic [NATIVE_ADDR_WDITH-1:0]  NATIVE_ADDR,
  input  logic [NATIVE_DATA_WIDTH-1:0]  NATIVE_DATA_IN,
  output logic [NATIVE_DATA_WIDTH-1:0]  NATIVE_DATA_OUT,
  output logic                          NATIVE_READY,
  output logic                          NATIVE_BUSY,
  output logic [1:0]                    NATIVE_RESP,
  output logic                          NATIVE_ERR,
  input  logic                          NATIVE_ERR_CLR,
  output logic [M_AXI_ADDR_WIDTH-1:0]   M_AXI_awaddr,
  output logic                          M_AXI_awvalid,
  input  logic                          M_AXI_awready,
  output logic [2:0]                    M_AXI_awprot,
  output logic [M_AXI_DATA_WIDTH-1:0]   M_AXI_wdata,
  output logic [M_AXI_DATA_WIDTH/8-1:0] M_AXI_wstrb,
  output logic                          M_AXI_wvalid,
  input  logic                          M_AXI_wready,
  input  logic [1:0]                    M_AXI_bresp,
  input  logic                          M_AXI_bvalid,
  output logic                          M_AXI_bready,
  output logic [M_AXI_ADDR_WIDTH-1:0]   M_AXI_araddr,
  output logic                          M_AXI_arvalid,
  input  logic                          M_AXI_arready,
  output logic [2:0]                    M_AXI_arprot,
  input  logic [M_AXI_DATA_WIDTH-1:0]   M_AXI_rdata,
  input  logic [1:0]                    M_AXI_rresp,
  input  logic                          M_AXI_rvalid,
  output logic                          M_AXI_rready
);

  localparam int unsigned ADDR_SHIFT = byte_shift(M_AXI_DATA_WIDTH);

  axil_state_e                  state_q;
  logic [M_AXI_ADDR_WIDTH-1:0]  addr_q;
  logic [M_AXI_ADDR_WIDTH-1:0]  addr_d;
  logic [M_AXI_DATA_WIDTH-1:0]  wdata_q;
  logic [M_AXI_DATA_WIDTH-1:0]  wdata_d;
  logic [NATIVE_DATA_WIDTH-1:0] data_out_q;
  logic [1:0]                   resp_q;
  logic awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic ready_q, err_q;
  logic aw_hs, w_hs, both_done, wr_start, wr_done, rd_done, err_set;

  assign addr_d  = BASE_ADDR + (M_AXI_ADDR_WIDTH'(NATIVE_ADDR) << ADDR_SHIFT);
  assign wdata_d = M_AXI_DATA_WIDTH'(NATIVE_DATA_IN);

  assign aw_hs    = awvalid_q & M_AXI_awready;
  assign w_hs     = wvalid_q & M_AXI_wready;
  assign wr_start = (state_q == IDLE) & NATIVE_EN & NATIVE_WR;
  assign wr_done  = (state_q == WRESP) & M_AXI_bvalid;
  assign rd_done  = (state_q == RDATA) & M_AXI_rvalid;

  // A request while busy is dropped but flagged, alongside any error response.
  assign err_set = (NATIVE_EN & (state_q != IDLE))
                 | (wr_done & (M_AXI_bresp != RESP_OKAY))
                 | (rd_done & (M_AXI_rresp != RESP_OKAY));

  axil_wr_channel_tracker u_wr_tracker (
    .clk         (M_AXI_aclk),
    .rst         (M_AXI_areset),
    .start_i     (wr_start),
    .aw_hs_i     (aw_hs),
    .w_hs_i      (w_hs),
    .both_done_o (both_done)
  );

  always_ff @(posedge M_AXI_aclk) begin
    if (M_AXI_areset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
      resp_q     <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: default-low here makes READY a single-cycle pulse; the
      // completing states override it with a later non-blocking assignment.
      ready_q <= 1'b0;
      if (NATIVE_ERR_CLR)  err_q <= 1'b0;
      else if (err_set)    err_q <= 1'b1;

      unique case (state_q)
        IDLE: begin
          if (NATIVE_EN) begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (NATIVE_WR) begin
              state_q   <= WRITE;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= RADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          if (both_done) begin
            state_q  <= WRESP;
            bready_q <= 1'b1;
          end
        end
        WRESP: begin
          if (M_AXI_bvalid) begin
            state_q  <= IDLE;
            bready_q <= 1'b0;
            resp_q   <= M_AXI_bresp;
            ready_q  <= 1'b1;
          end
        end
        RADDR: begin
          if (M_AXI_arready) begin
            state_q   <= RDATA;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        RDATA: begin
          if (M_AXI_rvalid) begin
            state_q    <= IDLE;
            rready_q   <= 1'b0;
            data_out_q <= M_AXI_rdata[NATIVE_DATA_WIDTH-1:0];
            resp_q     <= M_AXI_rresp;
            ready_q    <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign NATIVE_DATA_OUT = data_out_q;
  assign NATIVE_READY    = ready_q;
  assign NATIVE_BUSY     = (state_q != IDLE);
  assign NATIVE_RESP     = resp_q;
  assign NATIVE_ERR      = err_q;

  assign M_AXI_awaddr  = addr_q;
  assign M_AXI_araddr  = addr_q;
  assign M_AXI_awprot  = 3'b000;
  assign M_AXI_arprot  = 3'b000;
  assign M_AXI_awvalid = awvalid_q;
  assign M_AXI_wdata   = wdata_q;
  assign M_AXI_wstrb   = '1;
  assign M_AXI_wvalid  = wvalid_q;
  assign M_AXI_bready  = bready_q;
  assign M_AXI_arvalid = arvalid_q;
  assign M_AXI_rready  = rready_q;

endmodule

// File: tb/tb_native_axil_master.sv
// Bench for native_axil_master: delay-programmable AXI-Lite slave, a
// request-queue model checked every cycle, and directed scenario checks.
module tb_native_axil_master;
  import axil_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        areset;
  logic        en, wr, err_clr;
  logic [3:0]  addr;
  logic [31:0] din, dout;
  logic        ready, busy, err;
  logic [1:0]  resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  native_axil_master #(
    .NATIVE_ADDR_WDITH (4),
    .NATIVE_DATA_WIDTH (32),
    .M_AXI_ADDR_WIDTH  (32),
    .M_AXI_DATA_WIDTH  (32),
    .BASE_ADDR         (BASE)
  ) dut (
    .M_AXI_aclk      (clk),
    .M_AXI_areset    (areset),
    .NATIVE_EN       (en),
    .NATIVE_WR       (wr),
    .NATIVE_ADDR     (addr),
    .NATIVE_DATA_IN  (din),
    .NATIVE_DATA_OUT (dout),
    .NATIVE_READY    (ready),
    .NATIVE_BUSY     (busy),
    .NATIVE_RESP     (resp),
    .NATIVE_ERR      (err),
    .NATIVE_ERR_CLR  (err_clr),
    .M_AXI_awaddr    (awaddr),
    .M_AXI_awvalid   (awvalid),
    .M_AXI_awready   (awready),
    .M_AXI_awprot    (awprot),
    .M_AXI_wdata     (wdata),
    .M_AXI_wstrb     (wstrb),
    .M_AXI_wvalid    (wvalid),
    .M_AXI_wready    (wready),
    .M_AXI_bresp     (bresp),
    .M_AXI_bvalid    (bvalid),
    .M_AXI_bready    (bready),
    .M_AXI_araddr    (araddr),
    .M_AXI_arvalid   (arvalid),
    .M_AXI_arready   (arready),
    .M_AXI_arprot    (arprot),
    .M_AXI_rdata     (rdata),
    .M_AXI_rresp     (rresp),
    .M_AXI_rvalid    (rvalid),
    .M_AXI_rready    (rready)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- slave model ----------------
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0] b_resp_cfg = RESP_OKAY;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit aw_ok, w_ok, wr_pending, rd_pending, b_fire, r_fire;
  logic [31:0] pend_awaddr, pend_wdata, pend_araddr;
  int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, last_r_cyc = 0;
  logic [31:0] smem [logic [31:0]];

  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    smem[32'h0000_1004] = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (areset) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_ok = 0; w_ok = 0; wr_pending = 0; rd_pending = 0; b_fire = 0; r_fire = 0;
      end else begin
        // B before AW/W so a response never appears in its own handshake cycle
        if (b_fire) begin bvalid = 0; b_fire = 0; end
        else if (!bvalid && wr_pending) begin
          if (b_cnt == b_delay) begin bvalid = 1; bresp = b_resp_cfg; wr_pending = 0; b_cnt = 0; end
          else b_cnt++;
        end
        if (bvalid && bready && !b_fire) begin b_fire = 1; b_hs_n++; end

        if (r_fire) begin rvalid = 0; r_fire = 0; end
        else if (!rvalid && rd_pending) begin
          if (r_cnt == r_delay) begin
            rvalid = 1; rresp = RESP_OKAY; rd_pending = 0; r_cnt = 0;
            rdata = smem.exists(pend_araddr) ? smem[pend_araddr] : 32'h0;
          end else r_cnt++;
        end
        if (rvalid && rready && !r_fire) begin r_fire = 1; last_r_cyc = cyc; end

        if (awready) awready = 0;
        else if (awvalid && !aw_ok) begin
          if (aw_cnt == aw_delay) begin awready = 1; aw_cnt = 0; aw_ok = 1; pend_awaddr = awaddr; aw_hs_n++; end
          else aw_cnt++;
        end
        if (wready) wready = 0;
        else if (wvalid && !w_ok) begin
          if (w_cnt == w_delay) begin wready = 1; w_cnt = 0; w_ok = 1; pend_wdata = wdata; w_hs_n++; end
          else w_cnt++;
        end
        if (aw_ok && w_ok) begin
          smem[pend_awaddr] = pend_wdata; wr_pending = 1; aw_ok = 0; w_ok = 0;
        end

        if (arready) arready = 0;
        else if (arvalid && !rd_pending && !rvalid) begin
          if (ar_cnt == ar_delay) begin arready = 1; ar_cnt = 0; rd_pending = 1; pend_araddr = araddr; ar_hs_n++; end
          else ar_cnt++;
        end
      end
    end
  end

  // ---------------- request-level model + per-cycle compare ----------------
  typedef struct {
    bit          wr;
    logic [3:0]  waddr;
    logic [31:0] data;
    logic [1:0]  resp;
  } req_t;

  req_t        q[$];
  logic [31:0] mmem [16];
  int          ready_n = 0, awv_cyc = 0, wv_cyc = 0, arv_cyc = 0, issue_cyc = 0;
  logic [31:0] last_awaddr, last_wdata, last_araddr;
  logic [3:0]  last_wstrb;
  req_t        cur;

  initial begin
    forever begin
      @(negedge clk);
      if (!areset) begin
        if (awvalid || wvalid || arvalid) begin
          check("busy_with_valid", busy, 1);
          if (q.size() == 0) check("valid_without_request", 1, 0);
          else begin
            if (awvalid) begin
              awv_cyc++; last_awaddr = awaddr;
              check("aw_is_write", q[0].wr, 1);
              check("awaddr", awaddr, BASE + 32'(q[0].waddr) * 4);
              check("awprot", awprot, 0);
            end
            if (wvalid) begin
              wv_cyc++; last_wdata = wdata; last_wstrb = wstrb;
              check("w_is_write", q[0].wr, 1);
              check("wdata", wdata, q[0].data);
              check("wstrb", wstrb, 4'hF);
            end
            if (arvalid) begin
              arv_cyc++; last_araddr = araddr;
              check("ar_is_read", q[0].wr, 0);
              check("araddr", araddr, BASE + 32'(q[0].waddr) * 4);
              check("arprot", arprot, 0);
            end
          end
        end
        if (ready) begin
          ready_n++;
          if (q.size() == 0) check("ready_without_request", 1, 0);
          else begin
            cur = q.pop_front();
            check("resp", resp, cur.resp);
            check("busy_at_ready", busy, 0);
            if (!cur.wr) check("read_data", dout, cur.data);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input bit w, input logic [3:0] a, input logic [31:0] d);
    req_t r;
    en = 1; wr = w; addr = a; din = d;
    r.wr = w; r.waddr = a;
    r.data = w ? d : mmem[a];
    r.resp = w ? b_resp_cfg : RESP_OKAY;
    if (w) mmem[a] = d;
    q.push_back(r);
    issue_cyc = cyc;
    @(negedge clk);
    en = 0; wr = ~w; addr = ~a; din = ~d;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!ready && n < budget) begin @(negedge clk); n++; end
    if (!ready) check("ready_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int aw0, ar0, b0, r0, c0;
    int aw_tab [3] = '{3, 0, 2};
    int w_tab  [3] = '{0, 3, 2};

    for (int i = 0; i < 16; i++) mmem[i] = 32'h0;
    mmem[1] = 32'hDEAD_BEEF;
    areset = 1; en = 0; wr = 0; addr = 0; din = 0; err_clr = 0;
    repeat (3) @(negedge clk);
    check("reset_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    check("reset_busy_ready", {busy, ready}, 0);
    check("reset_dout", dout, 0);
    check("reset_resp_err", {resp, err}, 0);
    areset = 0;
    @(negedge clk);

    // zero-wait write
    issue(1, 4'd3, 32'hA5A5_0001);
    wait_ready(20);
    check("write_latency", cyc - issue_cyc, 3);
    check("write_awaddr_lit", last_awaddr, 32'h0000_100C);
    check("write_wdata_lit", last_wdata, 32'hA5A5_0001);
    check("write_wstrb_lit", last_wstrb, 4'hF);
    check("write_resp_lit", resp, 0);

    // read with arready and rvalid delays
    ar_delay = 4; r_delay = 2; arv_cyc = 0;
    issue(0, 4'd1, 32'h0);
    wait_ready(50);
    check("read_arvalid_cycles", arv_cyc, 5);
    check("read_ready_after_rvalid", cyc, last_r_cyc + 1);
    check("read_data_lit", dout, 32'hDEAD_BEEF);
    check("read_araddr_lit", last_araddr, 32'h0000_1004);
    ar_delay = 0; r_delay = 0;

    // write handshake orderings: W first, AW first, both together
    for (int k = 0; k < 3; k++) begin
      aw_delay = aw_tab[k]; w_delay = w_tab[k];
      awv_cyc = 0; wv_cyc = 0; b0 = b_hs_n; r0 = ready_n;
      issue(1, 4'(5 + k), 32'h0BAD_0000 + 32'(k));
      wait_ready(50);
      @(negedge clk);
      check("order_awvalid_cycles", awv_cyc, aw_tab[k] + 1);
      check("order_wvalid_cycles", wv_cyc, w_tab[k] + 1);
      check("order_b_handshakes", b_hs_n - b0, 1);
      check("order_ready_pulses", ready_n - r0, 1);
    end
    aw_delay = 0; w_delay = 0;

    // error response, stickiness, clear
    b_resp_cfg = RESP_SLVERR;
    issue(1, 4'd7, 32'h7777_7777);
    wait_ready(20);
    check("slverr_resp_lit", resp, 2);
    check("slverr_err_lit", err, 1);
    b_resp_cfg = RESP_OKAY;
    repeat (3) @(negedge clk);
    check("err_sticky", err, 1);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    check("err_cleared", err, 0);

    // request while busy is ignored but flagged
    ar_delay = 4; aw0 = aw_hs_n; ar0 = ar_hs_n;
    issue(0, 4'd2, 32'h0);
    en = 1; wr = 1; addr = 4'd9; din = 32'h9999_9999;
    @(negedge clk);
    en = 0;
    check("busy_en_sets_err", err, 1);
    wait_ready(50);
    @(negedge clk);
    check("busy_en_ar_count", ar_hs_n - ar0, 1);
    check("busy_en_no_aw", aw_hs_n - aw0, 0);

    // clear wins over a same-cycle set
    issue(0, 4'd3, 32'h0);
    en = 1; err_clr = 1;
    @(negedge clk);
    en = 0; err_clr = 0;
    check("clr_priority", err, 0);
    wait_ready(50);
    ar_delay = 0;
    @(negedge clk);

    // back-to-back alternating write/read, EN in each READY cycle
    r0 = ready_n; c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      issue(i % 2 == 0, 4'(10 + i / 2), 32'hC0DE_0000 + 32'(i * 17));
      wait_ready(20);
    end
    check("b2b_total_cycles", cyc - c0, 24);
    @(negedge clk);
    check("b2b_ready_pulses", ready_n - r0, 8);

    // reset while waiting in RDATA
    r_delay = 10;
    issue(0, 4'd1, 32'h0);
    for (int n = 0; n < 20 && !rready; n++) @(negedge clk);
    check("reached_rdata", rready, 1);
    areset = 1;
    q.delete();
    @(negedge clk);
    check("midreset_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    check("midreset_busy_ready", {busy, ready}, 0);
    check("midreset_dout", dout, 0);
    @(negedge clk);
    areset = 0; r_delay = 0;
    @(negedge clk);
    issue(0, 4'd1, 32'h0);
    wait_ready(20);
    check("post_reset_latency", cyc - issue_cyc, 3);
    check("post_reset_data_lit", dout, 32'hDEAD_BEEF);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
